ball_grid_scanner: RTL

Scans the 8-row × 5-column ball-sensor grid under the plate and produces the ball position consumed by the setpoint stage. The ball position is reported as `ball_detected`, `x_pos_calc` and `y_pos_calc`. The block drives the row multiplexer, samples the five column comparators per row, and reduces each full frame to a bounding-box midpoint. It applies a miss-frame hold-off so that momentary sensor dropouts do not clear detection.

---
 rtl/ball_grid_scanner.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ball_grid_scanner.sv
// Row-multiplexed scanner for the 8x5 ball-sensor grid: captures one image per
// frame and reduces it to a bounding-box midpoint with a miss-frame hold-off.
module ball_grid_scanner #(
  parameter int SETTLE_TICKS = 4,
  parameter int MISS_FRAMES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [4:0] col_in,
  output logic [2:0] row_sel,
  output logic       row_en,
  output logic       ball_detected,
  output logic [3:0] x_pos_calc,
  output logic [3:0] y_pos_calc,
  output logic       frame_valid
);

  typedef enum logic [1:0] {RESET_WAIT, SCAN, COMPUTE} state_t;

  localparam logic [3:0] T_LAST   = 4'(SETTLE_TICKS - 1);
  localparam logic [2:0] MISS_LIM = 3'(MISS_FRAMES);

  state_t          state;
  logic [2:0]      r;
  logic [3:0]      t;
  logic [7:0][4:0] img;
  logic [2:0]      m;
  logic [4:0]      col_p0;
  logic [4:0]      col_s;

  logic [7:0] row_hit;
  logic [4:0] col_hit;
  logic [2:0] rmin, rmax, cmin, cmax;
  logic [2:0] m_inc;

  function automatic logic [3:0] midpoint(input logic [2:0] lo, input logic [2:0] hi);
    logic [3:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return {1'b0, sum[3:1]};
  endfunction

  assign row_sel = r;
  assign m_inc   = (m == 3'd7) ? 3'd7 : m + 3'd1;

  // Stage p0/s: comparator synchroniser, runs every clk regardless of clk_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= '0;
      col_s  <= '0;
    end else begin
      col_p0 <= col_in;
      col_s  <= col_p0;
    end
  end

  always_comb begin
    row_hit = '0;
    col_hit = '0;
    rmin    = '0;
    rmax    = '0;
    cmin    = '0;
    cmax    = '0;
    for (int i = 0; i < 8; i++) begin
      row_hit[i] = |img[i];
      col_hit    = col_hit | img[i];
    end
    // Descending scans leave the lowest hit index; ascending ones the highest
    for (int i = 7; i >= 0; i--) if (row_hit[i]) rmin = 3'(i);
    for (int i = 0; i < 8; i++)  if (row_hit[i]) rmax = 3'(i);
    for (int j = 4; j >= 0; j--) if (col_hit[j]) cmin = 3'(j);
    for (int j = 0; j < 5; j++)  if (col_hit[j]) cmax = 3'(j);
  end

  // Scan/compute sequencer; frame_valid self-clears on every clk edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RESET_WAIT;
      r             <= '0;
      t             <= '0;
      img           <= '0;
      m             <= '0;
      row_en        <= 1'b0;
      ball_detected <= 1'b0;
      x_pos_calc    <= '0;
      y_pos_calc    <= '0;
      frame_valid   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (clk_en) begin
        case (state)
          RESET_WAIT: begin
            row_en <= 1'b1;
            r      <= '0;
            t      <= '0;
            img    <= '0;
            state  <= SCAN;
          end
          SCAN: begin
            if (t < T_LAST) begin
              t <= t + 4'd1;
            end else begin
              t      <= '0;
              img[r] <= col_s;
              if (r != 3'd7) begin
                r <= r + 3'd1;
              end else begin
                row_en <= 1'b0;
                state  <= COMPUTE;
              end
            end
          end
          COMPUTE: begin
            frame_valid <= 1'b1;
            if (|row_hit) begin
              x_pos_calc    <= midpoint(rmin, rmax);
              y_pos_calc    <= midpoint(cmin, cmax);
              ball_detected <= 1'b1;
              m             <= '0;
            end else begin
              m <= m_inc;
              if (m_inc >= MISS_LIM) ball_detected <= 1'b0;
            end
            r      <= '0;
            row_en <= 1'b1;
            img    <= '0;
            state  <= SCAN;
          end
          default: state <= RESET_WAIT;
        endcase
      end
    end
  end

endmodule
